// File: rtl/dl_report_engine_if.sv
// Report stream of the deadlock report engine: one record per beat, valid/ready handshake.
// The engine drives records and the sticky overflow flag; the consumer drives ready.
interface dl_report_engine_if #(
  parameter int IDX_W = 1
) ();
  logic             rpt_valid;
  logic             rpt_ready;
  logic [1:0]       rpt_kind;
  logic [IDX_W-1:0] rpt_idx;
  logic [7:0]       rpt_cycle;
  logic             rpt_overflow;

  modport master (
    output rpt_valid, rpt_kind, rpt_idx, rpt_cycle, rpt_overflow,
    input  rpt_ready
  );

  modport slave (
    input  rpt_valid, rpt_kind, rpt_idx, rpt_cycle, rpt_overflow,
    output rpt_ready
  );
endinterface

// File: rtl/dl_report_engine.sv
// Deadlock detector: filters a stable blocked-process pattern, then traces each token
// cycle through the processes and streams START/COMP/END records through a small FIFO.
module dl_report_engine #(
  parameter int PROC_NUM      = 2,
  parameter int FILTER_CYCLES = 1000,
  parameter int RPT_DEPTH     = 4
) (
  input  logic                dl_clock,
  input  logic                dl_reset,
  input  logic [PROC_NUM-1:0] dl_in_vec,
  output logic                dl_detect_out,
  output logic [PROC_NUM-1:0] origin,
  output logic                token_clear,
  dl_report_engine_if.master  rpt
);
  localparam int IDX_W = (PROC_NUM > 2) ? $clog2(PROC_NUM) : 1;
  localparam int AW    = $clog2(RPT_DEPTH);
  localparam logic [1:0] KIND_START = 2'b00;
  localparam logic [1:0] KIND_COMP  = 2'b01;
  localparam logic [1:0] KIND_END   = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FILTER   = 3'd1,
    ST_DETECTED = 3'd2,
    ST_REPORT   = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  typedef struct packed {
    logic [1:0]       kind;
    logic [IDX_W-1:0] idx;
    logic [7:0]       cyc;
  } rec_t;

  state_t              state_r, state_nxt_s;
  logic [31:0]         cnt_r, cnt_nxt_s;
  logic [PROC_NUM-1:0] detect_r, detect_nxt_s;
  logic [PROC_NUM-1:0] done_r, done_nxt_s;
  logic [PROC_NUM-1:0] origin_reg_r, origin_reg_nxt_s;
  logic [7:0]          cycle_id_r, cycle_id_nxt_s, cycle_prev_s;
  logic [PROC_NUM-1:0] origin_s;
  logic                token_clear_s;
  logic                push_s;
  rec_t                push_rec_s;

  rec_t                mem_r [RPT_DEPTH];
  logic [AW:0]         wr_ptr_r, rd_ptr_r;
  logic                overflow_r;
  logic                empty_s, full_s, pop_s, push_ok_s, drop_s;

  function automatic logic [IDX_W-1:0] idx_of(input logic [PROC_NUM-1:0] v);
    idx_of = '0;
    for (int i = 0; i < PROC_NUM; i++) begin
      if (v[i]) begin
        idx_of = IDX_W'(i);
      end else begin
        idx_of = idx_of;
      end
    end
  endfunction

  function automatic logic [PROC_NUM-1:0] onehot_hi(input logic [PROC_NUM-1:0] v);
    onehot_hi = '0;
    for (int i = 0; i < PROC_NUM; i++) begin
      if (v[i]) begin
        onehot_hi    = '0;
        onehot_hi[i] = 1'b1;
      end else begin
        onehot_hi = onehot_hi;
      end
    end
  endfunction

  // FSM next state, trace bookkeeping and record generation
  always_comb begin
    state_nxt_s      = state_r;
    cnt_nxt_s        = cnt_r;
    detect_nxt_s     = detect_r;
    done_nxt_s       = done_r;
    origin_reg_nxt_s = origin_reg_r;
    cycle_id_nxt_s   = cycle_id_r;
    cycle_prev_s     = cycle_id_r - 8'd1;
    origin_s         = '0;
    token_clear_s    = 1'b0;
    push_s           = 1'b0;
    push_rec_s       = '0;
    case (state_r)
      ST_IDLE: begin
        detect_nxt_s = dl_in_vec;
        cnt_nxt_s    = 32'd0;
        if (dl_in_vec != '0) begin
          state_nxt_s = ST_FILTER;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FILTER: begin
        if (cnt_r >= 32'(FILTER_CYCLES)) begin
          state_nxt_s = ST_DETECTED;
        end else if ((detect_r & ~dl_in_vec) != '0) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = 32'd0;
        end else if (cnt_r != 32'hFFFF_FFFF) begin
          cnt_nxt_s = cnt_r + 32'd1;
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      ST_DETECTED: begin
        origin_s = onehot_hi(detect_r & ~done_r);
        if (detect_r != done_r) begin
          push_s           = 1'b1;
          push_rec_s       = '{kind: KIND_START, idx: idx_of(origin_s), cyc: cycle_id_r};
          origin_reg_nxt_s = origin_s;
          cycle_id_nxt_s   = cycle_id_r + 8'd1;
          state_nxt_s      = ST_REPORT;
        end else begin
          push_s      = 1'b1;
          push_rec_s  = '{kind: KIND_END, idx: IDX_W'(cycle_prev_s), cyc: cycle_prev_s};
          state_nxt_s = ST_DONE;
        end
      end
      ST_REPORT: begin
        if ((dl_in_vec & origin_reg_r) != '0) begin
          token_clear_s = 1'b1;
          state_nxt_s   = ST_DETECTED;
        end else if (dl_in_vec != '0) begin
          push_s     = 1'b1;
          push_rec_s = '{kind: KIND_COMP, idx: idx_of(dl_in_vec), cyc: cycle_prev_s};
        end else begin
          push_s = 1'b0;
        end
        if ((dl_in_vec & detect_r) != '0) begin
          done_nxt_s = done_r | dl_in_vec;
        end else begin
          done_nxt_s = done_r;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_DONE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FIFO occupancy and push/pop arbitration; a pop frees room for a same-cycle push
  always_comb begin
    empty_s   = (wr_ptr_r == rd_ptr_r);
    full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    pop_s     = !empty_s && rpt.rpt_ready;
    push_ok_s = push_s && (!full_s || pop_s);
    drop_s    = push_s && full_s && !pop_s;
  end

  // State, trace registers, FIFO pointers and sticky overflow
  always_ff @(posedge dl_clock) begin
    if (dl_reset) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 32'd0;
      detect_r     <= '0;
      done_r       <= '0;
      origin_reg_r <= '0;
      cycle_id_r   <= 8'd1;
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      overflow_r   <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      detect_r     <= detect_nxt_s;
      done_r       <= done_nxt_s;
      origin_reg_r <= origin_reg_nxt_s;
      cycle_id_r   <= cycle_id_nxt_s;
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + (AW + 1)'(1);
      end
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + (AW + 1)'(1);
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Record storage; contents are only meaningful between the pointers
  always_ff @(posedge dl_clock) begin
    if (push_ok_s && !dl_reset) begin
      mem_r[wr_ptr_r[AW-1:0]] <= push_rec_s;
    end
  end

  assign dl_detect_out    = (|detect_r) &&
                            (state_r inside {ST_DETECTED, ST_REPORT, ST_DONE});
  assign origin           = origin_s;
  assign token_clear      = token_clear_s;
  assign rpt.rpt_valid    = !empty_s;
  assign rpt.rpt_kind     = mem_r[rd_ptr_r[AW-1:0]].kind;
  assign rpt.rpt_idx      = mem_r[rd_ptr_r[AW-1:0]].idx;
  assign rpt.rpt_cycle    = mem_r[rd_ptr_r[AW-1:0]].cyc;
  assign rpt.rpt_overflow = overflow_r;
endmodule

// File: tb/tb_dl_report_engine.sv
// Bench for dl_report_engine: two instances (FIFO depth 4 and 2) share the process flags
// and are compared every cycle against a queue-based reference model.
module tb_dl_report_engine;
  localparam int PN = 2;
  localparam int FC = 4;
  localparam int IW = 1;
  localparam int DA = 4;
  localparam int DB = 2;

  logic          dl_clock = 1'b0;
  logic          dl_reset;
  logic [PN-1:0] dl_in_vec;
  logic          det_a, det_b, tc_a, tc_b;
  logic [PN-1:0] org_a, org_b;
  int            n_checks = 0;
  int            n_errors = 0;

  dl_report_engine_if #(.IDX_W(IW)) rpt_a ();
  dl_report_engine_if #(.IDX_W(IW)) rpt_b ();

  dl_report_engine #(.PROC_NUM(PN), .FILTER_CYCLES(FC), .RPT_DEPTH(DA)) dut_a (
    .dl_clock(dl_clock), .dl_reset(dl_reset), .dl_in_vec(dl_in_vec),
    .dl_detect_out(det_a), .origin(org_a), .token_clear(tc_a), .rpt(rpt_a));

  dl_report_engine #(.PROC_NUM(PN), .FILTER_CYCLES(FC), .RPT_DEPTH(DB)) dut_b (
    .dl_clock(dl_clock), .dl_reset(dl_reset), .dl_in_vec(dl_in_vec),
    .dl_detect_out(det_b), .origin(org_b), .token_clear(tc_b), .rpt(rpt_b));

  always #5 dl_clock = ~dl_clock;

  // Reference model: phase names follow the specification's states
  localparam int P_IDLE = 0, P_FILTER = 1, P_DET = 2, P_REPORT = 3, P_DONE = 4;
  typedef struct packed {
    logic [1:0]    kind;
    logic [IW-1:0] idx;
    logic [7:0]    cyc;
  } rec_t;
  rec_t   qa[$], qb[$];
  int     m_phase, m_detect, m_done, m_oreg, m_cycle;
  longint m_cnt;
  bit     ovf_a, ovf_b;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int hi_idx(input int v);
    for (int i = PN - 1; i >= 0; i--) if (((v >> i) & 1) != 0) return i;
    return 0;
  endfunction

  function automatic int exp_origin();
    int cand;
    cand = m_detect & ~m_done & ((1 << PN) - 1);
    if (m_phase != P_DET || cand == 0) return 0;
    return 1 << hi_idx(cand);
  endfunction

  function automatic rec_t mk(input int kind, input int idx, input int cyc);
    rec_t r;
    r.kind = 2'(kind);
    r.idx  = IW'(idx % (1 << IW));
    r.cyc  = 8'(cyc % 256);
    return r;
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE; m_cnt = 0; m_detect = 0; m_done = 0; m_oreg = 0; m_cycle = 1;
    qa.delete(); qb.delete(); ovf_a = 1'b0; ovf_b = 1'b0;
  endtask

  task automatic check_fifo(input string tag, input logic v, input logic [1:0] k,
                            input logic [IW-1:0] i, input logic [7:0] c, input logic ov,
                            input int size, input rec_t head, input bit movf);
    check_val({tag, "_valid"}, 32'(v), 32'(size != 0));
    check_val({tag, "_ovf"}, 32'(ov), 32'(movf));
    if (size != 0) begin
      check_val({tag, "_kind"}, 32'(k), 32'(head.kind));
      check_val({tag, "_idx"}, 32'(i), 32'(head.idx));
      check_val({tag, "_cycle"}, 32'(c), 32'(head.cyc));
    end
  endtask

  task automatic compare_outputs();
    int din, eo;
    bit etc, edet;
    din  = int'(dl_in_vec);
    eo   = exp_origin();
    etc  = (m_phase == P_REPORT) && ((din & m_oreg) != 0);
    edet = (m_detect != 0) && (m_phase >= P_DET);
    check_val("detect_a", 32'(det_a), 32'(edet));
    check_val("detect_b", 32'(det_b), 32'(edet));
    check_val("origin_a", 32'(org_a), 32'(eo));
    check_val("origin_b", 32'(org_b), 32'(eo));
    check_val("tclear_a", 32'(tc_a), 32'(etc));
    check_val("tclear_b", 32'(tc_b), 32'(etc));
    check_fifo("fifo_a", rpt_a.rpt_valid, rpt_a.rpt_kind, rpt_a.rpt_idx, rpt_a.rpt_cycle,
               rpt_a.rpt_overflow, qa.size(), (qa.size() != 0) ? qa[0] : rec_t'(0), ovf_a);
    check_fifo("fifo_b", rpt_b.rpt_valid, rpt_b.rpt_kind, rpt_b.rpt_idx, rpt_b.rpt_cycle,
               rpt_b.rpt_overflow, qb.size(), (qb.size() != 0) ? qb[0] : rec_t'(0), ovf_b);
  endtask

  task automatic model_step();
    int   din, o, prev;
    bit   push, full_a, full_b, pop_a, pop_b;
    rec_t r;
    if (dl_reset) begin
      model_reset();
      return;
    end
    din  = int'(dl_in_vec);
    push = 1'b0;
    r    = '0;
    prev = (m_cycle + 255) % 256;
    case (m_phase)
      P_IDLE: begin
        m_detect = din; m_cnt = 0;
        if (din != 0) m_phase = P_FILTER;
      end
      P_FILTER: begin
        if (m_cnt >= FC) m_phase = P_DET;
        else if ((m_detect & ~din) != 0) begin m_phase = P_IDLE; m_cnt = 0; end
        else if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
      end
      P_DET: begin
        if (m_detect != m_done) begin
          o = exp_origin();
          push = 1'b1; r = mk(0, hi_idx(o), m_cycle);
          m_oreg = o; m_cycle = (m_cycle + 1) % 256; m_phase = P_REPORT;
        end else begin
          push = 1'b1; r = mk(2, prev, prev); m_phase = P_DONE;
        end
      end
      P_REPORT: begin
        if ((din & m_oreg) != 0) m_phase = P_DET;
        else if (din != 0) begin push = 1'b1; r = mk(1, hi_idx(din), prev); end
        if ((din & m_detect) != 0) m_done = m_done | din;
      end
      default: ;
    endcase
    full_a = (qa.size() == DA); pop_a = (qa.size() != 0) && rpt_a.rpt_ready;
    full_b = (qb.size() == DB); pop_b = (qb.size() != 0) && rpt_b.rpt_ready;
    if (pop_a) void'(qa.pop_front());
    if (pop_b) void'(qb.pop_front());
    if (push) begin
      if (!full_a || pop_a) qa.push_back(r); else ovf_a = 1'b1;
      if (!full_b || pop_b) qb.push_back(r); else ovf_b = 1'b1;
    end
  endtask

  task automatic cyc(input logic [PN-1:0] v, input logic ra, input logic rb, input logic rst);
    dl_in_vec       = v;
    rpt_a.rpt_ready = ra;
    rpt_b.rpt_ready = rb;
    dl_reset        = rst;
    @(negedge dl_clock);
    compare_outputs();
    model_step();
    @(posedge dl_clock);
    #1;
  endtask

  initial begin
    dl_reset = 1'b1; dl_in_vec = '0; rpt_a.rpt_ready = 1'b1; rpt_b.rpt_ready = 1'b1;
    @(posedge dl_clock);
    #1;
    model_reset();
    cyc(2'b00, 1'b1, 1'b1, 1'b1);
    check_val("rst_detect", 32'(det_a), 32'd0);
    check_val("rst_valid", 32'(rpt_a.rpt_valid), 32'd0);
    check_val("rst_ovf", 32'(rpt_b.rpt_overflow), 32'd0);
    check_val("rst_origin", 32'(org_a), 32'd0);

    // fake stall
    repeat (3) cyc(2'b01, 1'b1, 1'b1, 1'b0);
    repeat (3) cyc(2'b00, 1'b1, 1'b1, 1'b0);
    check_val("stall_detect", 32'(det_a), 32'd0);
    check_val("stall_valid", 32'(rpt_a.rpt_valid), 32'd0);

    // true deadlock; depth-2 instance held in backpressure
    repeat (7) cyc(2'b01, 1'b1, 1'b0, 1'b0);
    cyc(2'b10, 1'b1, 1'b0, 1'b0);
    cyc(2'b01, 1'b1, 1'b0, 1'b0);
    repeat (2) cyc(2'b00, 1'b1, 1'b0, 1'b0);
    check_val("dl_done_detect", 32'(det_a), 32'd1);
    check_val("bp_ovf", 32'(rpt_b.rpt_overflow), 32'd1);
    check_val("bp_head_kind", 32'(rpt_b.rpt_kind), 32'd0);
    repeat (3) cyc(2'b00, 1'b1, 1'b1, 1'b0);
    check_val("bp_drained", 32'(rpt_b.rpt_valid), 32'd0);

    // two token cycles
    cyc(2'b00, 1'b1, 1'b1, 1'b1);
    repeat (7) cyc(2'b11, 1'b1, 1'b1, 1'b0);
    cyc(2'b10, 1'b1, 1'b1, 1'b0);
    cyc(2'b00, 1'b1, 1'b1, 1'b0);
    cyc(2'b01, 1'b1, 1'b1, 1'b0);
    repeat (3) cyc(2'b00, 1'b1, 1'b1, 1'b0);
    check_val("two_detect", 32'(det_a), 32'd1);

    // reset mid-REPORT discards pending records
    cyc(2'b00, 1'b1, 1'b1, 1'b1);
    repeat (7) cyc(2'b01, 1'b1, 1'b0, 1'b0);
    cyc(2'b10, 1'b1, 1'b0, 1'b0);
    cyc(2'b00, 1'b1, 1'b0, 1'b1);
    check_val("midrst_valid", 32'(rpt_b.rpt_valid), 32'd0);
    check_val("midrst_detect", 32'(det_a), 32'd0);
    repeat (8) cyc(2'b01, 1'b1, 1'b1, 1'b0);

    // full FIFO with a simultaneous pop accepts the push
    cyc(2'b00, 1'b1, 1'b1, 1'b1);
    repeat (7) cyc(2'b01, 1'b1, 1'b0, 1'b0);
    cyc(2'b10, 1'b1, 1'b0, 1'b0);
    cyc(2'b10, 1'b1, 1'b1, 1'b0);
    cyc(2'b00, 1'b1, 1'b1, 1'b0);
    check_val("simul_ovf", 32'(rpt_b.rpt_overflow), 32'd0);

    // randomized held patterns with random backpressure and occasional reset
    cyc(2'b00, 1'b1, 1'b1, 1'b1);
    for (int n = 0; n < 600; n++) begin
      logic [PN-1:0] v;
      int hold;
      v    = PN'($urandom_range(0, (1 << PN) - 1));
      hold = $urandom_range(1, 8);
      for (int h = 0; h < hold; h++) begin
        cyc(v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 79) == 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/dl_report_engine.md
DL_REPORT_ENGINE -- requirements
Module: dl_report_engine

Interface
REQ-001 SHALL have parameter PROC_NUM, default 2: number of monitored dataflow processes (>=2).
REQ-002 SHALL have parameter FILTER_CYCLES, default 1000: consecutive stable cycles needed to confirm a deadlock.
REQ-003 SHALL have parameter RPT_DEPTH, default 4: report FIFO depth, a power of 2 (>=2).
REQ-004 SHALL define IDX_W = max(1, clog2(PROC_NUM)) for process index fields.
REQ-005 SHALL have port dl_clock, input, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port dl_reset, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port dl_in_vec, input, PROC_NUM: per-process blocked or token-holding flag.
REQ-008 SHALL have port dl_detect_out, output, 1: deadlock confirmed.
REQ-009 SHALL have port origin, output, PROC_NUM: one-hot start process of the cycle currently being traced.
REQ-010 SHALL have port token_clear, output, 1: the token has returned to its origin.
REQ-011 SHALL have port rpt_valid, output, 1, and port rpt_ready, input, 1: report stream handshake.
REQ-012 SHALL have port rpt_kind, output, 2: 00 START, 01 COMP, 10 END.
REQ-013 SHALL have port rpt_idx, output, IDX_W: process index; cycle count for END, truncated to IDX_W.
REQ-014 SHALL have port rpt_cycle, output, 8: cycle id, modulo 256.
REQ-015 SHALL have port rpt_overflow, output, 1: sticky flag, set when a record was dropped.

Function
REQ-016 SHALL implement FSM states IDLE, FILTER, DETECTED, REPORT, DONE.
REQ-017 In IDLE, each cycle SHALL load detect_reg<=dl_in_vec and clear the filter counter; if dl_in_vec!=0, next state SHALL be FILTER.
REQ-018 In FILTER:
- cnt>=FILTER_CYCLES: SHALL go to DETECTED (this test has priority).
- else, if detect_reg is not a subset of dl_in_vec: SHALL go to IDLE and clear cnt.
- else: SHALL increment cnt, saturating at 2^32-1.
REQ-019 In DETECTED, origin SHALL be one-hot of the highest index j with detect_reg[j]&~done_reg[j]; origin SHALL be 0 in every other state.
REQ-020 In DETECTED with detect_reg!=done_reg, the block SHALL:
- push START(idx(origin), cycle_id);
- set origin_reg<=origin;
- increment cycle_id;
- go to REPORT.
REQ-021 In DETECTED with detect_reg==done_reg, the block SHALL push END(idx=cycle_id-1, cycle=cycle_id-1) and go to DONE.
REQ-022 In REPORT with dl_in_vec&origin_reg!=0, token_clear SHALL be 1 combinationally for that cycle and next state SHALL be DETECTED.
REQ-023 In REPORT with dl_in_vec!=0 and dl_in_vec&origin_reg==0, the block SHALL push COMP(idx(dl_in_vec), cycle_id-1) and stay in REPORT.
REQ-024 In REPORT with dl_in_vec==0, the block SHALL stay in REPORT and push nothing.
REQ-025 In REPORT, whenever dl_in_vec&detect_reg!=0, the block SHALL set done_reg<=done_reg|dl_in_vec.
REQ-026 idx(v) SHALL be the index of the highest set bit of v, and 0 when v=0.
REQ-027 DONE SHALL be terminal until reset, and no further pushes SHALL occur in DONE.
REQ-028 dl_detect_out SHALL equal |detect_reg AND state in {DETECTED, REPORT, DONE}.
REQ-029 The FIFO SHALL meet the following:
- rpt_valid SHALL be 1 exactly when the FIFO is non-empty.
- The head SHALL be driven on rpt_kind, rpt_idx and rpt_cycle.
- The head SHALL pop when rpt_valid&rpt_ready.
- Head fields SHALL stay stable while rpt_valid&~rpt_ready.
REQ-030 A push to a full FIFO in the same cycle as a pop SHALL succeed; a push to a full FIFO without a pop SHALL be dropped and SHALL set rpt_overflow.
REQ-031 Report backpressure SHALL never stall the FSM.
REQ-032 A push and a pop on an empty FIFO in the same cycle SHALL NOT bypass: the pushed record SHALL appear on the next cycle.
REQ-033 rpt_cycle and cycle_id SHALL wrap modulo 256 without error.

Reset
REQ-034 With dl_reset=1 at a rising edge, the next state SHALL be IDLE.
REQ-035 With dl_reset=1 at a rising edge, the block SHALL clear all of: cnt, detect_reg, done_reg, origin_reg, cycle_id (reset value 1), FIFO pointers, rpt_overflow.
REQ-036 The resulting output values SHALL be dl_detect_out=0, origin=0, token_clear=0, rpt_valid=0, rpt_overflow=0.
REQ-037 Reset asserted mid-operation, in any state, SHALL abort the trace and discard pending records.

Verification (PROC_NUM=2, FILTER_CYCLES=4, RPT_DEPTH=4 unless noted)
REQ-038 Fake stall: dl_in_vec=01 for 3 cycles then 00 -> return to IDLE, dl_detect_out stays 0, rpt_valid stays 0.
REQ-039 True deadlock: dl_in_vec=01 held until DETECTED -> origin=01 for one cycle and START(0,1); then dl_in_vec=10 -> COMP(1,1); then 01 -> token_clear=1; then END(1,1); then DONE with dl_detect_out=1.
REQ-040 Two cycles: detect_reg=11 -> first START uses idx 1, second START uses idx 0 with rpt_cycle=2, END reports count 2.
REQ-041 Backpressure: rpt_ready=0 during the REQ-039 trace with RPT_DEPTH=2 -> first 2 records retained, later pushes dropped, rpt_overflow=1; rpt_ready=1 then drains START, COMP in order.
REQ-042 Reset mid-REPORT: dl_reset=1 for one cycle -> state IDLE, rpt_valid=0, dl_detect_out=0, cycle_id restarts at 1.
REQ-043 Simultaneous events: with the FIFO full and rpt_ready=1, a COMP push -> accepted, rpt_overflow stays 0.
